window_gen_3x3: RTL
===================

Name: window_gen_3x3

Overview:
- Producer end of the 3x3 window interface consumed by the convolution MAC.
- Accepts a raster-order pixel stream and buffers two previous image lines.
- Emits a packed 72-bit 3x3 neighbourhood with a valid strobe for every fully-interior window position; no padding is applied.
- Sits between the pixel source (camera/DMA stream) and the MAC stage.

Parameters:
DATA_WIDTH, 8, bits per pixel
KERNEL_SIZE, 3, window edge; only 3 is supported, any other value is a compile-time error
IMG_WIDTH, 8, pixels per line (>= 3)
IMG_HEIGHT, 8, lines per frame (>= 3)

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
pix_in  input  DATA_WIDTH  incoming pixel, raster order
pix_valid  input  1  pix_in accepted on every rising edge where high; no backpressure
sof_in  input  1  start-of-frame; qualified by pix_valid, marks that pixel as (row 0, col 0)
window_out  output  DATA_WIDTH*9  packed window {p0..p8}; p0 (MSB) = top-left, p8 (LSB) = bottom-right = newest pixel
win_valid  output  1  one-cycle strobe, window_out valid
frame_done  output  1  one-cycle strobe after the last pixel of a frame is accepted

Behaviour:
- Reset (async, rst_n low):
  - window_out, win_valid, frame_done, window registers, col, row all clear to 0.
  - Line-buffer RAM contents are not reset; they are don't-care.
- Counters:
  - col 0..IMG_WIDTH-1, row 0..IMG_HEIGHT-1.
  - Both advance only on accepted pixels.
  - col wraps to 0 and row increments after col = IMG_WIDTH-1.
  - row wraps to 0 after the last line.
- sof_in & pix_valid: the pixel is processed as (0,0) regardless of the counter values. Counters then become col=1, row=0. This resyncs mid-frame.
- On each accepted pixel at (row r, col c):
  - Read lb1[c] (line r-1) and lb2[c] (line r-2).
  - Write lb2[c] <= lb1[c] and lb1[c] <= pix_in.
  - Shift the 3x3 window registers one column left. The new right column is {lb2[c], lb1[c], pix_in}, top to bottom.
- Output timing:
  - win_valid = 1 on the cycle after an accepted pixel with r >= 2 and c >= 2.
  - window_out registered in the same cycle: row r-2 cols c-2..c -> p0..p2; row r-1 -> p3..p5; row r -> p6..p8.
  - Latency is 1 clk.
- Windows never straddle a line: positions c = 0,1 and rows 0,1 produce no strobe. Expected count per frame is (IMG_WIDTH-2)*(IMG_HEIGHT-2) strobes.
- pix_valid low: all state holds, win_valid = 0, frame_done = 0. window_out holds its last value.
- frame_done = 1 on the cycle after accepting pixel (IMG_HEIGHT-1, IMG_WIDTH-1). It is coincident with the final win_valid.
- sof_in without pix_valid is ignored.
- Reset mid-frame: counters return to 0 and no strobe is issued until two full new lines plus 3 pixels have been accepted. Stale line-buffer data never appears in a valid window.

Decomposition:
- Shared package: DATA_WIDTH default, window packing order (p-index to row/col mapping), and a WIN_BITS = DATA_WIDTH*9 constant. The MAC uses the same constants.
- One sub-module, line_buf_ram: single-port, IMG_WIDTH x DATA_WIDTH, synchronous write, combinational read.
  - Instantiated twice (lb1, lb2), addressed by col.
- Counters, window shift registers and output registers live in the top level.

Test Plan:
1. Full 8x8 frame, pix_valid constant high, pixel = row*8+col.
   - First win_valid comes 1 clk after pixel 18.
   - window_out = {0,1,2,8,9,10,16,17,18}.
   - Exactly 36 strobes per frame.
   - Last window = {45,46,47,53,54,55,61,62,63}.
   - frame_done pulses once, coincident with the last strobe.
2. Same frame with pix_valid toggling in a random 50% pattern.
   - Identical sequence of 36 windows.
   - Outputs hold and no strobes occur during gaps.
3. Back-to-back frames, second frame pixel = 100+row*8+col.
   - No strobes in rows 0-1 of frame 2.
   - First frame-2 window = {100,101,102,108,109,110,116,117,118}.
4. sof_in asserted at frame-1 pixel (3,5).
   - Counters resync to (0,0).
   - Next strobe only after 18 further accepted pixels (new (2,2)).
   - No window mixes post-resync rows 0-2 with pre-resync data positions.
5. rst_n pulsed low mid-row 4 (asynchronous, between edges).
   - All outputs are 0 immediately.
   - After release, behaviour is identical to scenario 1 from a fresh start.
6. Row-boundary check.
   - No strobe for pixels (3,0) or (3,1).
   - The strobe for (3,2) contains only columns 0-2.

Source files
------------

// File: rtl/window_gen_3x3_pkg.sv
// Constants shared by the 3x3 window producer and the convolution MAC.
// Window packing: p0 (MSB) is top-left, p8 (LSB) is bottom-right, row-major.
package window_gen_3x3_pkg;

  localparam int WG_DATA_WIDTH = 8;
  localparam int WG_KERNEL     = 3;
  localparam int WG_WIN_PIX    = WG_KERNEL * WG_KERNEL;
  localparam int WG_WIN_BITS   = WG_DATA_WIDTH * WG_WIN_PIX;

  // p-index of the pixel at (row, col) inside the window, row 0 = oldest line
  function automatic int wg_p_index(input int row, input int col);
    return row * WG_KERNEL + col;
  endfunction

  // LSB position of pixel p inside a packed window of dw-bit pixels
  function automatic int wg_p_lsb(input int p, input int dw);
    return (WG_WIN_PIX - 1 - p) * dw;
  endfunction

endpackage

// File: rtl/window_gen_3x3_line_buf_ram.sv
// One image line of pixel storage: synchronous write, combinational read.
// Latency: read 0 clk, write lands on the clock edge; no backpressure.
module line_buf_ram #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             i_clk,
  input  logic             i_wr_en,
  input  logic [AW-1:0]    i_addr,
  input  logic [WIDTH-1:0] i_wr_dat,
  output logic [WIDTH-1:0] o_rd_dat
);

  logic [WIDTH-1:0] r_mem [DEPTH];

  // Contents are never reset; the top only exposes data rewritten since reset.
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_mem[i_addr] <= i_wr_dat;
    end
  end

  assign o_rd_dat = r_mem[i_addr];

endmodule

// File: rtl/window_gen_3x3.sv
// Raster pixel stream in, packed 3x3 interior windows out; 1 clk latency.
// No backpressure: every pix_valid cycle accepts a pixel, idle cycles hold all state.
module window_gen_3x3
  import window_gen_3x3_pkg::*;
#(
  parameter int DATA_WIDTH  = WG_DATA_WIDTH,
  parameter int KERNEL_SIZE = WG_KERNEL,
  parameter int IMG_WIDTH   = 8,
  parameter int IMG_HEIGHT  = 8
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [DATA_WIDTH-1:0]            pix_in,
  input  logic                             pix_valid,
  input  logic                             sof_in,
  output logic [DATA_WIDTH*WG_WIN_PIX-1:0] window_out,
  output logic                             win_valid,
  output logic                             frame_done
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT - 1);
  localparam logic [CW-1:0] COL_FIRST = CW'(WG_KERNEL - 1);
  localparam logic [RW-1:0] ROW_FIRST = RW'(WG_KERNEL - 1);

  generate
    if (KERNEL_SIZE != 3) begin : g_bad_kernel
      $error("window_gen_3x3: only KERNEL_SIZE = 3 is supported");
    end
    if (IMG_WIDTH < 3 || IMG_HEIGHT < 3) begin : g_bad_image
      $error("window_gen_3x3: IMG_WIDTH and IMG_HEIGHT must be >= 3");
    end
  endgenerate

  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [CW-1:0] w_col;
  logic [RW-1:0] w_row;
  logic [CW-1:0] w_col_nxt;
  logic [RW-1:0] w_row_nxt;
  logic          w_sof;
  logic          w_win_pos;
  logic          w_last_pix;

  logic [DATA_WIDTH-1:0] w_lb1_rd;
  logic [DATA_WIDTH-1:0] w_lb2_rd;

  // Index 2 is the leftmost (oldest) column, index 0 the newest.
  logic [2:0][DATA_WIDTH-1:0] r_top, r_mid, r_bot;
  logic [2:0][DATA_WIDTH-1:0] w_top_nxt, w_mid_nxt, w_bot_nxt;

  // A qualified start-of-frame overrides the counters for this very pixel.
  assign w_sof = sof_in & pix_valid;
  assign w_col = w_sof ? '0 : r_col;
  assign w_row = w_sof ? '0 : r_row;

  assign w_win_pos  = (w_row >= ROW_FIRST) && (w_col >= COL_FIRST);
  assign w_last_pix = (w_row == ROW_LAST) && (w_col == COL_LAST);

  always_comb begin
    w_col_nxt = w_col + CW'(1);
    w_row_nxt = w_row;
    if (w_col == COL_LAST) begin
      w_col_nxt = '0;
      w_row_nxt = (w_row == ROW_LAST) ? '0 : w_row + RW'(1);
    end
  end

  line_buf_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_lb1 (
    .i_clk    (clk),
    .i_wr_en  (pix_valid),
    .i_addr   (w_col),
    .i_wr_dat (pix_in),
    .o_rd_dat (w_lb1_rd)
  );

  line_buf_ram #(
    .DEPTH (IMG_WIDTH),
    .WIDTH (DATA_WIDTH)
  ) u_lb2 (
    .i_clk    (clk),
    .i_wr_en  (pix_valid),
    .i_addr   (w_col),
    .i_wr_dat (w_lb1_rd),
    .o_rd_dat (w_lb2_rd)
  );

  assign w_top_nxt = {r_top[1:0], w_lb2_rd};
  assign w_mid_nxt = {r_mid[1:0], w_lb1_rd};
  assign w_bot_nxt = {r_bot[1:0], pix_in};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col <= '0;
      r_row <= '0;
      r_top <= '0;
      r_mid <= '0;
      r_bot <= '0;
    end else if (pix_valid) begin
      r_col <= w_col_nxt;
      r_row <= w_row_nxt;
      r_top <= w_top_nxt;
      r_mid <= w_mid_nxt;
      r_bot <= w_bot_nxt;
    end
  end

  // window_out only reloads on a strobe, so it holds the last valid window.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      window_out <= '0;
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
      if (pix_valid) begin
        frame_done <= w_last_pix;
        if (w_win_pos) begin
          win_valid  <= 1'b1;
          window_out <= {w_top_nxt, w_mid_nxt, w_bot_nxt};
        end
      end
    end
  end

endmodule
